// File: rtl/ix_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ix_scoreboard_pkg
// Purpose  : Shared register-index width and writeback-port indices for the
//            issue scoreboard.
// Revision : 1.0
// ============================================================================
package ix_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Writeback port assignment: integer pipe and load/store pipe
    localparam int WB_IP  = 0;
    localparam int WB_LSP = 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ix_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ix_sb_cnt
// Purpose  : In-flight write counter for one architectural register; saturates
//            on overflow/underflow and flags the protocol error.
// Revision : 1.0
// ============================================================================
module ix_sb_cnt
    import ix_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             err_o
);

    localparam int EW = max_i(CNT_W, DEC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_dec;
    logic             w_inc;
    logic             w_over;
    logic             w_under;

    assign full_o = (cnt_q == CNT_MAX);
    assign cnt_o  = cnt_q;

    // Sum is formed one bit wider so the underflow compare sees the true value
    always_comb begin
        w_inc   = issue_i && !full_o;
        w_over  = issue_i && full_o;
        w_sum   = EW'(cnt_q) + EW'(w_inc);
        w_dec   = EW'(dec_i);
        w_under = (w_dec > w_sum);
        cnt_d   = w_under ? '0 : CNT_W'(w_sum - w_dec);
        err_o   = w_over || w_under;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ix_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ix_scoreboard
// Purpose  : Per-register pending-write scoreboard for x1..x31 with RAW/WAW
//            readiness, idle and sticky error. Option macro: IX_SB_BYPASS_EN
//            (same-cycle writeback makes a source ready).
// Revision : 1.0
// ============================================================================
module ix_scoreboard
    import ix_scoreboard_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int NUM_WB = 2,
    parameter int CNT_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RS*REG_IDX_W-1:0]   rs_addr,
    output logic [NUM_RS-1:0]             rs_ready,
    input  logic [REG_IDX_W-1:0]          rd_addr,
    output logic                          rd_ready,
    input  logic                          issue_valid,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*REG_IDX_W-1:0]   wb_dst,
    output logic                          sb_idle,
    output logic                          sb_err
);

    localparam int DEC_W = $clog2(NUM_WB + 1);
    localparam int EW    = max_i(CNT_W, DEC_W);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [DEC_W-1:0]    w_dec [NUM_REGS];
    logic [NUM_REGS-1:0] w_full;
    logic [NUM_REGS-1:0] w_err;
    logic                w_busy;
    logic                err_q;
    logic                err_d;

    // x0 has no storage: it reads as permanently empty
    assign w_cnt[0]  = '0;
    assign w_dec[0]  = '0;
    assign w_full[0] = 1'b0;
    assign w_err[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic             w_issue_r;
        logic [DEC_W-1:0] w_dec_r;

        assign w_issue_r = issue_valid && (rd_addr == REG_IDX_W'(r));

        always_comb begin
            w_dec_r = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && (wb_dst[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))) begin
                    w_dec_r = w_dec_r + DEC_W'(1);
                end
            end
        end

        assign w_dec[r] = w_dec_r;

        ix_sb_cnt #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .issue_i (w_issue_r),
            .dec_i   (w_dec_r),
            .cnt_o   (w_cnt[r]),
            .full_o  (w_full[r]),
            .err_o   (w_err[r])
        );
    end

    for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
        reg_idx_t w_a;
        assign w_a = rs_addr[k*REG_IDX_W +: REG_IDX_W];
`ifdef IX_SB_BYPASS_EN
        // Writebacks retiring every pending write this cycle clear the hazard
        assign rs_ready[k] = (w_a == '0) || (w_cnt[w_a] == '0) ||
                             (EW'(w_cnt[w_a]) == EW'(w_dec[w_a]));
`else
        assign rs_ready[k] = (w_a == '0) || (w_cnt[w_a] == '0);
`endif
    end

    assign rd_ready = (rd_addr == '0) || !w_full[rd_addr];

    always_comb begin
        w_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_busy = w_busy || (w_cnt[r] != '0);
        end
    end

    assign sb_idle = !w_busy;

    assign err_d = err_q || (|w_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sb_err = err_q;

endmodule
`default_nettype wire

// File: doc/ix_scoreboard.md
IX_SCOREBOARD -- requirements
Module: ix_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RS, default 2: number of source-register check ports.
REQ-002 SHALL have parameter NUM_WB, default 2: number of writeback ports (IP, LSP).
REQ-003 SHALL have parameter CNT_W, default 2: width of each in-flight counter; max in-flight writes per register = 2^CNT_W-1.
REQ-004 SHALL have ports `clk` (input, 1) and `rst` (input, 1); single clock; reset is synchronous and active-high.
REQ-005 SHALL have `rs_addr` (input, NUM_RS*5): source register numbers, port k at bits [5k+4:5k].
REQ-006 SHALL have `rs_ready` (output, NUM_RS): source k has no pending write.
REQ-007 SHALL have `rd_addr` (input, 5): destination of the instruction being issued.
REQ-008 SHALL have `rd_ready` (output, 1): the counter for rd_addr can accept one more write.
REQ-009 SHALL have `issue_valid` (input, 1): allocate one pending write to rd_addr this cycle.
REQ-010 SHALL have `wb_valid` (input, NUM_WB) and `wb_dst` (input, NUM_WB*5): per-port writeback retire.
REQ-011 SHALL have `sb_idle` (output, 1): all counters are zero.
REQ-012 SHALL have `sb_err` (output, 1): sticky protocol-error flag.

Function
REQ-013 SHALL keep one CNT_W-bit counter per register x1..x31; x0 SHALL have no storage.
REQ-014 Next count SHALL equal count + inc - dec, computed in one cycle; inc = issue_valid && rd_addr==r && rd_addr!=0 && rd_ready; dec = number of wb_valid ports with wb_dst==r (0..NUM_WB).
REQ-015 Simultaneous issue and writeback to the same register SHALL apply both (net change).
REQ-016 Two or more writeback ports naming the same register in one cycle SHALL each decrement.
REQ-017 Writebacks to x0 SHALL be ignored.
REQ-018 rs_ready[k] SHALL be combinational from registered counters: 1 if rs_addr[k]==0 or count==0.
REQ-019 rd_ready SHALL be 1 if rd_addr==0 or count < 2^CNT_W-1; WAW up to the limit SHALL be allowed.
REQ-020 issue_valid with rd_ready==0 SHALL leave the counter unchanged and set sb_err.
REQ-021 Underflow (dec > count + inc) SHALL saturate the count at 0 and set sb_err.
REQ-022 sb_idle SHALL be 1 when every counter is 0, from registered state.
REQ-023 sb_err SHALL stay set until reset.
REQ-024 The block SHALL NOT react to pipeline flush; in-flight writes still retire through wb_valid.

Reset
REQ-025 On a rising edge with rst=1, all counters SHALL become 0 and sb_err 0; issue_valid and wb_valid SHALL be ignored in that cycle.
REQ-026 After reset, outputs SHALL be rs_ready all 1, rd_ready 1, sb_idle 1, sb_err 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending counts.

Configuration
REQ-028 Macro IX_SB_BYPASS_EN: when defined, rs_ready[k] SHALL also be 1 when count == dec for that register in the same cycle (same-cycle writeback makes the source ready, and the issue logic forwards the writeback value).
REQ-029 Without IX_SB_BYPASS_EN, rs_ready SHALL depend only on registered counts; the bypass costs one stall cycle.

Structure
REQ-030 SHALL place in the shared defines file: register-index width (5) and the writeback-port indices (WB_IP=0, WB_LSP=1).
REQ-031 SHALL use one sub-module, ix_sb_cnt (a single-register counter with inc, dec count, saturation and error output), generated 31 times.

Verification
REQ-032 Reset, then issue rd=5 -> next cycle rs_addr=5 gives rs_ready=0, sb_idle=0; wb_valid[0] with dst=5 -> next cycle rs_ready=1, sb_idle=1.
REQ-033 CNT_W=2: issue rd=7 three times -> rd_ready=0; a fourth issue is ignored and sb_err=1; three writebacks return the count to 0.
REQ-034 Count(9)=1: issue rd=9 with wb_valid[1] dst=9 in the same cycle -> count stays 1, rs_ready(9)=0.
REQ-035 Count(3)=2: wb_valid=2'b11, both dst=3 -> count 0 next cycle; a further wb to 3 -> sb_err=1, count stays 0.
REQ-036 With IX_SB_BYPASS_EN, count(4)=1 and wb dst=4 -> rs_ready=1 in the same cycle; without the macro -> 0, then 1 the next cycle.
REQ-037 Issue rd=0 and wb dst=0 -> no state change; rs_addr=0 always gives rs_ready=1.
